// File: rtl/multdiv_ctrl.sv
// Issue/stall sequencer for the shared multi-cycle multiply/divide unit.
// Launches one op at a time, freezes the pipeline meanwhile, and hands the result to writeback.
module multdiv_ctrl #(
  parameter logic [4:0] OP_MUL  = 5'b00110,
  parameter logic [4:0] OP_DIV  = 5'b00111,
  parameter int         TIMEOUT = 40,
  parameter int         CNT_W   = 6
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        x_valid,
  input  logic [4:0]  x_opcode,
  input  logic [4:0]  x_aluop,
  input  logic [4:0]  x_rd,
  input  logic        flush,
  input  logic        md_rdy,
  input  logic        md_exc,
  output logic        ctrl_mult,
  output logic        ctrl_div,
  output logic        stall,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_status,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  // Handshake: a result transfers on a cycle where wb_valid and wb_ready are both high;
  // wb_valid, wb_rd and wb_status hold steady while wb_valid is high and wb_ready is low.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic [4:0]       rd_q, rd_n;
  logic             div_q, div_n;
  logic             exc_q, exc_n;
  logic             tmo_q, tmo_n;
  logic             mult_n, divs_n;
  logic             is_md, is_div, cnt_max;

  assign is_div  = (x_aluop == OP_DIV);
  assign is_md   = x_valid && (x_opcode == 5'd0) && ((x_aluop == OP_MUL) || is_div);
  assign cnt_max = (cnt == CNT_W'(TIMEOUT - 1));
  assign cnt_inc = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      rd_q      <= 5'd0;
      div_q     <= 1'b0;
      exc_q     <= 1'b0;
      tmo_q     <= 1'b0;
      ctrl_mult <= 1'b0;
      ctrl_div  <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      rd_q      <= rd_n;
      div_q     <= div_n;
      exc_q     <= exc_n;
      tmo_q     <= tmo_n;
      ctrl_mult <= mult_n;
      ctrl_div  <= divs_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rd_n    = rd_q;
    div_n   = div_q;
    exc_n   = exc_q;
    tmo_n   = tmo_q;
    mult_n  = 1'b0;
    divs_n  = 1'b0;
    case (state)
      IDLE: begin
        if (is_md && !flush) begin
          state_n = BUSY;
          cnt_n   = '0;
          rd_n    = x_rd;
          div_n   = is_div;
          exc_n   = 1'b0;
          tmo_n   = 1'b0;
          mult_n  = !is_div;
          divs_n  = is_div;
        end
      end
      BUSY: begin
        cnt_n = cnt_inc;
        // A result arriving with the squash is simply dropped; nothing is left to drain.
        if (md_rdy && flush) begin
          state_n = IDLE;
        end else if (md_rdy) begin
          state_n = DONE;
          exc_n   = md_exc;
        end else if (flush) begin
          state_n = DRAIN;
          cnt_n   = '0;
        end else if (cnt_max) begin
          state_n = DONE;
          tmo_n   = 1'b1;
        end
      end
      DRAIN: begin
        cnt_n = cnt_inc;
        if (md_rdy || cnt_max) state_n = IDLE;
      end
      DONE: begin
        if (wb_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    wb_valid  = (state == DONE);
    wb_rd     = 5'd0;
    wb_status = 32'd0;
    if (state == DONE) begin
      wb_rd = (exc_q || tmo_q) ? 5'd30 : rd_q;
      if (tmo_q)      wb_status = 32'd7;
      else if (exc_q) wb_status = div_q ? 32'd5 : 32'd4;
    end
  end

  assign stall = ((state == IDLE) && is_md && !flush) || (state == BUSY)
              || ((state == DRAIN) && is_md) || ((state == DONE) && !wb_ready);
  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed bench for multdiv_ctrl: issue, exception, flush/drain, timeout,
// back-to-back ops and asynchronous reset, with hand-computed expectations.
module tb_multdiv_ctrl;

  localparam logic [4:0] OP_MUL = 5'b00110;
  localparam logic [4:0] OP_DIV = 5'b00111;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        x_valid, flush, md_rdy, md_exc, wb_ready;
  logic [4:0]  x_opcode, x_aluop, x_rd;
  logic        ctrl_mult, ctrl_div, stall, wb_valid, busy;
  logic [4:0]  wb_rd;
  logic [31:0] wb_status;
  logic [1:0]  dbg_state;

  int errors = 0;
  int checks = 0;
  int stall_cnt, mult_cnt, div_cnt, both_hi, wb_cyc, div_first, drain_bad, nwb;
  int wb_cycs[2];
  logic [4:0] wb_rds[2];

  multdiv_ctrl dut (
    .clock(clock), .reset_n(reset_n), .x_valid(x_valid), .x_opcode(x_opcode),
    .x_aluop(x_aluop), .x_rd(x_rd), .flush(flush), .md_rdy(md_rdy), .md_exc(md_exc),
    .ctrl_mult(ctrl_mult), .ctrl_div(ctrl_div), .stall(stall), .wb_valid(wb_valid),
    .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_status(wb_status), .busy(busy),
    .dbg_state(dbg_state)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clr();
    x_valid = 0; x_opcode = 5'd0; x_aluop = 5'd0; x_rd = 5'd0;
    flush = 0; md_rdy = 0; md_exc = 0; wb_ready = 0;
  endtask

  task automatic tally();
    if (stall) stall_cnt++;
    if (ctrl_mult) mult_cnt++;
    if (ctrl_div) div_cnt++;
    if (ctrl_mult && ctrl_div) both_hi++;
  endtask

  task automatic zero_cnts();
    stall_cnt = 0; mult_cnt = 0; div_cnt = 0; both_hi = 0; wb_cyc = -1; nwb = 0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 0);
    chk({tag, "_strobes"}, {30'd0, ctrl_mult, ctrl_div}, 0);
    chk({tag, "_wb_valid"}, {31'd0, wb_valid}, 0);
    chk({tag, "_wb_rd"}, {27'd0, wb_rd}, 0);
    chk({tag, "_wb_status"}, wb_status, 0);
    chk({tag, "_state"}, {30'd0, dbg_state}, 0);
  endtask

  initial begin
    clr();
    reset_n = 0;
    repeat (2) @(posedge clock);
    #1;
    check_all_zero("reset");
    chk("reset_stall", {31'd0, stall}, 0);
    reset_n = 1;
    step();

    // MUL rd=5, md_rdy at cycle 17, writeback ready throughout.
    zero_cnts();
    for (int i = 0; i < 21; i++) begin
      x_valid = (i == 0); x_aluop = OP_MUL; x_rd = 5'd5;
      md_rdy = (i == 17); wb_ready = 1;
      #1;
      tally();
      if (i == 1) chk("mul_strobe_c1", {30'd0, ctrl_mult, ctrl_div}, 2'b10);
      if (wb_valid && wb_cyc < 0) begin
        wb_cyc = i;
        chk("mul_wb_rd", {27'd0, wb_rd}, 5);
        chk("mul_wb_status", wb_status, 0);
      end
      step();
    end
    clr();
    chk("mul_stall_cycles", stall_cnt, 18);
    chk("mul_strobe_count", mult_cnt, 1);
    chk("mul_div_strobe_count", div_cnt, 0);
    chk("mul_wb_cycle", wb_cyc, 18);
    chk("mul_idle_after", {31'd0, busy}, 0);

    // DIV rd=9 with exception, writeback held off for three cycles.
    zero_cnts();
    for (int i = 0; i < 11; i++) begin
      x_valid = (i == 0); x_aluop = OP_DIV; x_rd = 5'd9;
      md_rdy = (i == 5); md_exc = (i == 5); wb_ready = (i >= 9);
      #1;
      tally();
      if (i == 1) chk("div_strobe_c1", {30'd0, ctrl_mult, ctrl_div}, 2'b01);
      if (i >= 6 && i <= 9) begin
        chk($sformatf("div_wb_valid_c%0d", i), {31'd0, wb_valid}, 1);
        chk($sformatf("div_wb_rd_c%0d", i), {27'd0, wb_rd}, 30);
        chk($sformatf("div_wb_status_c%0d", i), wb_status, 5);
        chk($sformatf("div_stall_c%0d", i), {31'd0, stall}, (i < 9) ? 1 : 0);
      end
      if (i == 10) chk("div_idle_after", {30'd0, busy, wb_valid}, 0);
      step();
    end
    clr();
    chk("div_strobe_count", div_cnt, 1);

    // Flush with is_md in IDLE: no issue.
    x_valid = 1; x_aluop = OP_MUL; x_rd = 5'd3; flush = 1;
    #1;
    chk("idle_flush_stall", {31'd0, stall}, 0);
    step();
    clr();
    #1;
    chk("idle_flush_no_issue", {30'd0, busy, ctrl_mult}, 0);
    step();

    // MUL flushed at cycle 4, squashed result at 17; DIV shows up in X mid-drain.
    zero_cnts(); drain_bad = 0;
    for (int i = 0; i < 19; i++) begin
      x_valid = (i == 0) || (i == 10); x_aluop = (i == 10) ? OP_DIV : OP_MUL;
      x_rd = 5'd3; flush = (i == 4); md_rdy = (i == 17); wb_ready = 1;
      #1;
      tally();
      if (i >= 5 && i <= 17 && i != 10)
        if (stall || wb_valid || dbg_state != 2'd2) drain_bad++;
      if (i == 10) chk("drain_is_md_stall", {31'd0, stall}, 1);
      if (i == 10) chk("drain_state", {30'd0, dbg_state}, 2);
      if (i == 18) chk("drain_idle_at_18", {31'd0, busy}, 0);
      step();
    end
    clr();
    chk("drain_quiet_cycles", drain_bad, 0);
    chk("drain_strobes", mult_cnt * 4 + div_cnt, 4);

    // md_rdy and flush together in BUSY: discard and return to IDLE.
    for (int i = 0; i < 5; i++) begin
      x_valid = (i == 0); x_aluop = OP_MUL; x_rd = 5'd6;
      md_rdy = (i == 3); flush = (i == 3); wb_ready = 1;
      #1;
      if (i == 4) chk("rdy_flush_idle", {30'd0, busy, wb_valid}, 0);
      step();
    end
    clr();

    // No md_rdy ever: forced completion after 40 BUSY cycles.
    wb_cyc = -1;
    for (int i = 0; i < 60; i++) begin
      x_valid = (i == 0); x_aluop = OP_MUL; x_rd = 5'd7; wb_ready = 0;
      #1;
      if (wb_valid) begin
        wb_cyc = i;
        break;
      end
      step();
    end
    x_valid = 0;
    chk("tmo_wb_cycle", wb_cyc, 41);
    chk("tmo_wb_rd", {27'd0, wb_rd}, 30);
    chk("tmo_wb_status", wb_status, 7);
    chk("tmo_stall_held", {31'd0, stall}, 1);
    wb_ready = 1;
    #1;
    chk("tmo_stall_drop", {31'd0, stall}, 0);
    step();
    clr();
    #1;
    chk("tmo_idle_after", {31'd0, busy}, 0);
    step();

    // Back-to-back MUL then DIV held in X until the first result retires.
    zero_cnts(); div_first = -1;
    for (int i = 0; i < 13; i++) begin
      x_valid = (i <= 6); x_aluop = (i == 0) ? OP_MUL : OP_DIV;
      x_rd = (i == 0) ? 5'd1 : 5'd2; md_rdy = (i == 4) || (i == 9); wb_ready = 1;
      #1;
      tally();
      if (ctrl_div && div_first < 0) div_first = i;
      if (i == 2) chk("b2b_stall_wait", {31'd0, stall}, 1);
      if (wb_valid && wb_ready && nwb < 2) begin
        wb_cycs[nwb] = i; wb_rds[nwb] = wb_rd; nwb++;
      end
      step();
    end
    clr();
    chk("b2b_handshakes", nwb, 2);
    chk("b2b_wb1_cycle", wb_cycs[0], 5);
    chk("b2b_wb1_rd", {27'd0, wb_rds[0]}, 1);
    chk("b2b_div_first", div_first, 7);
    chk("b2b_wb2_cycle", wb_cycs[1], 10);
    chk("b2b_wb2_rd", {27'd0, wb_rds[1]}, 2);
    chk("b2b_strobe_counts", mult_cnt * 4 + div_cnt, 5);
    chk("b2b_never_both", both_hi, 0);

    // Asynchronous reset while the strobe is high, then a clean reissue.
    x_valid = 1; x_aluop = OP_MUL; x_rd = 5'd8;
    step();
    x_valid = 0;
    #1;
    chk("areset_pre_strobe", {31'd0, ctrl_mult}, 1);
    reset_n = 0;
    #1;
    check_all_zero("areset");
    step();
    reset_n = 1;
    step();
    zero_cnts();
    for (int i = 0; i < 8; i++) begin
      x_valid = (i == 0); x_aluop = OP_MUL; x_rd = 5'd4; md_rdy = (i == 3); wb_ready = 1;
      #1;
      tally();
      if (i == 1) chk("reissue_strobe", {30'd0, ctrl_mult, ctrl_div}, 2'b10);
      if (wb_valid && wb_cyc < 0) begin
        wb_cyc = i;
        chk("reissue_wb_rd", {27'd0, wb_rd}, 4);
      end
      step();
    end
    clr();
    chk("reissue_wb_cycle", wb_cyc, 4);
    chk("reissue_strobe_count", mult_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
